perceptron_update_sched: RTL and testbench

PERCEPTRON_UPDATE_SCHED -- requirements
Module: perceptron_update_sched

---
 rtl/perceptron_update_sched.sv | 146 ++++++++++++++
 tb/tb_perceptron_update_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/perceptron_update_sched.sv
`default_nettype none
// ============================================================================
// perceptron_update_sched: queues perceptron training events and spends idle
// weight-table cycles on per-bank +/-1 writes.
// Optional stats counters: PERCEPTRON_SCHED_STATS_EN.  Revision: 1.0
// ============================================================================
module perceptron_update_sched #(
  parameter int FB_DEPTH     = 4,
  parameter int IDX_W        = 10,
  parameter int NUM_BANKS    = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  input  logic             i_fb_valid,
  input  logic [IDX_W-1:0] i_fb_index,
  input  logic             i_fb_taken,
  input  logic             i_fb_train,
  output logic             o_fb_ready,
  output logic             o_upd_en,
  output logic [IDX_W-1:0] o_upd_index,
  output logic [BANK_W-1:0] o_upd_bank,
  output logic             o_upd_taken,
  output logic             o_req_stall,
  output logic             o_busy
`ifdef PERCEPTRON_SCHED_STATS_EN
  ,
  output logic [15:0]      o_drop_cnt,
  output logic [15:0]      o_force_cnt
`endif
);

  localparam int PTR_W = $clog2(FB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_UPDATE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [BANK_W-1:0]      bank_q, bank_d;
  logic [STV_W-1:0]       starve_q, starve_d;
  logic [IDX_W:0]         mem_q [FB_DEPTH];
  logic [IDX_W:0]         mem_d [FB_DEPTH];

  logic w_full, w_push, w_drop, w_force, w_issue, w_last, w_pop;

  always_comb begin
    w_full  = (count_q == CNT_W'(FB_DEPTH));
    w_push  = i_fb_valid & i_fb_train & ~w_full;
    w_drop  = i_fb_valid & i_fb_train & w_full;
    w_force = (state_q == S_UPDATE) && (starve_q == STV_W'(STARVE_LIMIT));
    w_issue = (state_q == S_UPDATE) && (!i_req_valid || w_force);
    w_last  = (bank_q == BANK_W'(NUM_BANKS - 1));
    w_pop   = w_issue & w_last;

    mem_d = mem_q;
    if (w_push) mem_d[wr_ptr_q] = {i_fb_index, i_fb_taken};
    wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    state_d  = state_q;
    bank_d   = bank_q;
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      starve_d = '0;
      bank_d   = '0;
      if (count_q != '0) state_d = S_UPDATE;
    end else if (w_issue) begin
      starve_d = '0;
      if (w_last) begin
        bank_d = '0;
        // A push landing on the final slot keeps the FSM busy without a bubble
        if (count_d == '0) state_d = S_IDLE;
      end else begin
        bank_d = bank_q + BANK_W'(1);
      end
    end else begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      bank_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      bank_q   <= bank_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    o_fb_ready  = ~w_full;
    o_upd_en    = w_issue;
    o_upd_index = w_issue ? mem_q[rd_ptr_q][IDX_W:1] : '0;
    o_upd_taken = w_issue ? mem_q[rd_ptr_q][0] : 1'b0;
    o_upd_bank  = w_issue ? bank_q : '0;
    o_req_stall = w_issue & i_req_valid;
    o_busy      = (count_q != '0) || (state_q != S_IDLE);
  end

`ifdef PERCEPTRON_SCHED_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] force_cnt_q, force_cnt_d;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    force_cnt_d = force_cnt_q;
    if (w_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (o_req_stall && force_cnt_q != 16'hFFFF) force_cnt_d = force_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q  <= '0;
      force_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      force_cnt_q <= force_cnt_d;
    end
  end

  assign o_drop_cnt  = drop_cnt_q;
  assign o_force_cnt = force_cnt_q;
`else
  logic w_unused;
  assign w_unused = w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_perceptron_update_sched.sv
`default_nettype none
// Bench for perceptron_update_sched: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_perceptron_update_sched;

  localparam int DEPTH = 4;
  localparam int IW    = 10;
  localparam int NB    = 4;
  localparam int LIM   = 8;

  logic clk = 1'b0;
  logic rst, i_req_valid, i_fb_valid, i_fb_taken, i_fb_train;
  logic [IW-1:0] i_fb_index;
  logic o_fb_ready, o_upd_en, o_upd_taken, o_req_stall, o_busy;
  logic [IW-1:0] o_upd_index;
  logic [1:0] o_upd_bank;
`ifdef PERCEPTRON_SCHED_STATS_EN
  logic [15:0] o_drop_cnt, o_force_cnt;
`endif

  perceptron_update_sched #(
    .FB_DEPTH(DEPTH), .IDX_W(IW), .NUM_BANKS(NB), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .i_req_valid(i_req_valid),
    .i_fb_valid(i_fb_valid), .i_fb_index(i_fb_index),
    .i_fb_taken(i_fb_taken), .i_fb_train(i_fb_train),
    .o_fb_ready(o_fb_ready), .o_upd_en(o_upd_en),
    .o_upd_index(o_upd_index), .o_upd_bank(o_upd_bank),
    .o_upd_taken(o_upd_taken), .o_req_stall(o_req_stall),
    .o_busy(o_busy)
`ifdef PERCEPTRON_SCHED_STATS_EN
    , .o_drop_cnt(o_drop_cnt), .o_force_cnt(o_force_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IW-1:0] idx; logic tk; } ent_t;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int n_en, n_stall;

  // Reference model: pending training events plus scheduler progress
  ent_t mq[$];
  bit   m_init = 0;
  bit   m_upd  = 0;
  int   m_bank = 0;
  int   m_st   = 0;
  int   m_drop = 0;
  int   m_force = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic cyc(input bit rv, input bit req, input bit fbv,
                     input logic [IW-1:0] idx, input bit tk, input bit tr);
    bit e_en, e_stall, e_force, pushc, popped;
    int sz0;
    ent_t dummy;
    rst = rv; i_req_valid = req; i_fb_valid = fbv;
    i_fb_index = idx; i_fb_taken = tk; i_fb_train = tr;
    #4;
    e_force = m_upd && (m_st == LIM);
    e_en    = m_upd && (!req || e_force);
    e_stall = e_en && req;
    if (m_init) begin
      chk("ready", 32'(o_fb_ready), 32'(mq.size() < DEPTH));
      chk("busy",  32'(o_busy), 32'(mq.size() != 0 || m_upd));
      chk("upd_en", 32'(o_upd_en), 32'(e_en));
      chk("stall", 32'(o_req_stall), 32'(e_stall));
      chk("bank",  32'(o_upd_bank), e_en ? 32'(m_bank) : 32'd0);
      chk("index", 32'(o_upd_index), e_en ? 32'(mq[0].idx) : 32'd0);
      chk("taken", 32'(o_upd_taken), e_en ? 32'(mq[0].tk) : 32'd0);
`ifdef PERCEPTRON_SCHED_STATS_EN
      chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
      chk("force_cnt", 32'(o_force_cnt), 32'(m_force));
`endif
    end
    if (o_upd_en === 1'b1) n_en++;
    if (o_req_stall === 1'b1) n_stall++;
    @(posedge clk); #1;
    cyc_n++;
    if (rv) begin
      mq.delete(); m_upd = 0; m_bank = 0; m_st = 0;
      m_drop = 0; m_force = 0; m_init = 1;
    end else if (m_init) begin
      sz0 = mq.size();
      pushc = fbv && tr && (sz0 < DEPTH);
      popped = 0;
      if (fbv && tr && !pushc && m_drop < 65535) m_drop++;
      if (m_upd) begin
        if (e_en) begin
          if (e_stall && m_force < 65535) m_force++;
          m_st = 0;
          if (m_bank == NB - 1) begin
            dummy = mq.pop_front(); popped = 1; m_bank = 0;
          end else m_bank++;
        end else m_st++;
      end
      if (pushc) mq.push_back('{idx: idx, tk: tk});
      if (!m_upd) begin
        if (sz0 != 0) begin m_upd = 1; m_bank = 0; end
        m_st = 0;
      end else if (popped && mq.size() == 0) m_upd = 0;
    end
  endtask

  task automatic idle(input int n, input bit req);
    for (int i = 0; i < n; i++) cyc(0, req, 0, '0, 0, 0);
  endtask

  initial begin
    rst = 1; i_req_valid = 0; i_fb_valid = 0; i_fb_index = '0;
    i_fb_taken = 0; i_fb_train = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0);
    idle(2, 0);

    // single event, uncontended: four slots on T+2..T+5 then idle
    n_en = 0;
    cyc(0, 0, 1, 10'h2A, 1, 1);
    idle(7, 0);
    chk("single_slots", 32'(n_en), 32'd4);
    chk("single_busy", 32'(o_busy), 32'd0);

    // non-training feedback is discarded
    cyc(0, 0, 1, 10'h155, 1, 0);
    cyc(0, 1, 1, 10'h0F0, 0, 0);
    idle(3, 0);
    chk("notrain_busy", 32'(o_busy), 32'd0);

    // fill under contention, fifth dropped, then drain by forced slots only
    n_en = 0; n_stall = 0;
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, IW'(10'h100 + i), i[0], 1);
    chk("full_ready", 32'(o_fb_ready), 32'd0);
    idle(150, 1);
    chk("forced_slots", 32'(n_stall), 32'd16);
    chk("forced_en", 32'(n_en), 32'd16);

    // two entries back to back without contention
    n_en = 0;
    cyc(0, 0, 1, 10'h011, 0, 1);
    cyc(0, 0, 1, 10'h322, 1, 1);
    idle(10, 0);
    chk("b2b_slots", 32'(n_en), 32'd8);

    // reset right after bank 1 issues
    cyc(0, 0, 1, 10'h3C3, 1, 1);
    idle(3, 0);
    cyc(1, 0, 0, '0, 0, 0);
    idle(1, 0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_fb_ready), 32'd1);

    // random traffic with occasional contention bursts and resets
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1), IW'($urandom), $urandom_range(0, 1),
          ($urandom_range(0, 3) != 0));
    end
    idle(200, 0);
    chk("final_busy", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
